rv64g_l1_vlsu_bank_sched: RTL
=============================

# rv64g_l1_vlsu_bank_sched

Vector load/store bank scheduler for the L1 VLSU path; it is the producer side of the lane/bank tag-lookup interface that `rv64g_l1_vlsu_hit_detect` consumes. It accepts one multi-lane request and resolves bank conflicts over successive cycles. Each cycle it issues per-bank tag-array reads and, one cycle later, drives `bank_active`/`bank_src_lane` aligned with the returned tag/state data. It signals `done_o` when every valid lane has been looked up.

## Interface
- NUM_LANES, 8, vector lanes per request
- NUM_BANKS, 8, tag banks; bank = addr[3+BANK_W-1:3], BANK_W = $clog2(NUM_BANKS)
- INDEX_W, 5, set index width; index = addr[INDEX_W+5:6]
- LANE_W, $clog2(NUM_LANES), lane id width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept; high only in IDLE
- req_lane_addr_i  in  NUM_LANES*64  lane byte addresses, lane i at [(i+1)*64-1 -: 64]
- req_lane_valid_i  in  NUM_LANES  active-lane mask
- kill_i  in  1  abort the in-flight request
- lane_addr_o  out  NUM_LANES*64  captured addresses; stable from acceptance until the next acceptance
- tag_rd_en_o  out  NUM_BANKS  per-bank tag/state SRAM read enable (1-cycle read latency)
- tag_rd_index_o  out  NUM_BANKS*INDEX_W  per-bank set index
- bank_active_o  out  NUM_BANKS  bank returned data this beat
- bank_src_lane_o  out  NUM_BANKS*LANE_W  lane owning each active bank's data; 0 when inactive
- beat_lane_mask_o  out  NUM_LANES  lanes covered by this beat
- beat_valid_o  out  1  beat outputs valid
- done_o  out  1  one-cycle pulse: request fully looked up
- busy_o  out  1  state != IDLE

## Operation
- States are IDLE and ISSUE. Registers:
  - `pending[NUM_LANES]`
  - the address capture
  - a beat output stage (bank_active, bank_src_lane, beat_lane_mask, beat_valid, done)
- IDLE: on req_valid_i & req_ready_o, capture the addresses and set `pending` = req_lane_valid_i.
  - Non-zero mask: go to ISSUE.
  - Zero mask: stay in IDLE; done_o pulses next cycle with beat_valid_o=0 and no reads issued.
- ISSUE, combinational grant from `pending`:
  - For each bank b, grant the lowest-numbered pending lane L whose bank is b.
  - Also cover every other pending lane with addr[63:3] equal to lane L's (word coalescing).
  - Drive tag_rd_en_o[b]=1 and tag_rd_index_o[b]=index(L); both are 0 for banks with no grant.
- At the clock edge:
  - Clear all covered lanes from `pending`.
  - Register bank_active=granted banks, bank_src_lane[b]=L, beat_lane_mask=covered lanes, beat_valid=1.
- If `pending` becomes empty: register done=1 together with that final beat and go to IDLE.
- kill_i in ISSUE:
  - Clear `pending` and go to IDLE.
  - Suppress the beat for that cycle's grants: beat_valid=0, bank_active=0, done=0.
  - tag_rd_en_o is still asserted that cycle; it is harmless.
- kill_i in IDLE is ignored, including in the same cycle as an acceptance.
- Lanes with req_lane_valid_i=0 are never granted and never appear in beat_lane_mask_o.

## Timing
- Reset values:
  - state=IDLE, pending=0, captured addresses=0.
  - All beat outputs 0, tag_rd_en_o=0, done_o=0, busy_o=0, req_ready_o=1.
- Reset mid-request discards everything; no beat or done follows.
- Request accepted at cycle 0 → first tag read at cycle 1 → first beat at cycle 2 (aligned with SRAM data).
- N beats = max over banks of distinct addr[63:3] groups. The last beat arrives at cycle N+1, with done_o in the same cycle.
- Back-to-back requests:
  - req_ready_o is high in the cycle the final beat is presented, so the next request's first read can be at cycle N+2.
  - lane_addr_o switches to the new request only at that new acceptance edge. The prior beat therefore sees the prior addresses.
- Beat outputs are registered and last exactly one cycle. beat_valid_o=0 on non-beat cycles.

## Test plan
- Unit stride: addr 0x2000+8*i, mask 0xFF.
  - Cycle 1: tag_rd_en_o=0xFF, every index=0 (0x2000[10:6]).
  - Cycle 2: bank_active_o=0xFF, bank_src_lane b=b, beat_lane_mask_o=0xFF, done_o=1.
- Full conflict: addr 0x1000+64*i, all lanes in bank 0.
  - Eight beats, cycles 2-9: bank_active_o=0x01, src_lane=0..7, mask=1<<k.
  - tag_rd_index_o[0] steps 0..7. done_o only at cycle 9.
- Coalescing: all lanes at addr 0x3008, mask 0xFF → one beat with bank_active_o=0x02, src_lane[1]=0, mask=0xFF, done_o=1.
- Partial mask 0x05 (unit stride) → one beat with bank_active_o=0x05, mask=0x05. Lanes 1,3-7 never reported.
- Kill: full-conflict request, kill_i at cycle 4.
  - Beats only at cycles 2-4, with src_lane 0..2.
  - No beat at cycle 5 and no done_o.
  - req_ready_o=1 at cycle 5; a new request is accepted cleanly.
- Edge cases:
  - rst asserted at cycle 3 of a full-conflict request → all outputs go to reset values immediately and stay quiet after release.
  - Zero-mask request → done_o at cycle 1 with tag_rd_en_o=0 throughout.

Source files
------------

// File: rtl/rv64g_l1_vlsu_bank_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : rv64g_l1_vlsu_bank_sched_if
// Brief    : Request, tag-read and beat signals of the VLSU bank scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface rv64g_l1_vlsu_bank_sched_if #(
  parameter int NUM_LANES = 8,
  parameter int NUM_BANKS = 8,
  parameter int INDEX_W   = 5,
  parameter int LANE_W    = $clog2(NUM_LANES)
);
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [NUM_LANES*64-1:0]       req_lane_addr_i;
  logic [NUM_LANES-1:0]          req_lane_valid_i;
  logic                          kill_i;
  logic [NUM_LANES*64-1:0]       lane_addr_o;
  logic [NUM_BANKS-1:0]          tag_rd_en_o;
  logic [NUM_BANKS*INDEX_W-1:0]  tag_rd_index_o;
  logic [NUM_BANKS-1:0]          bank_active_o;
  logic [NUM_BANKS*LANE_W-1:0]   bank_src_lane_o;
  logic [NUM_LANES-1:0]          beat_lane_mask_o;
  logic                          beat_valid_o;
  logic                          done_o;
  logic                          busy_o;

  modport slave (
    input  req_valid_i, req_lane_addr_i, req_lane_valid_i, kill_i,
    output req_ready_o, lane_addr_o, tag_rd_en_o, tag_rd_index_o,
           bank_active_o, bank_src_lane_o, beat_lane_mask_o,
           beat_valid_o, done_o, busy_o
  );

  modport master (
    output req_valid_i, req_lane_addr_i, req_lane_valid_i, kill_i,
    input  req_ready_o, lane_addr_o, tag_rd_en_o, tag_rd_index_o,
           bank_active_o, bank_src_lane_o, beat_lane_mask_o,
           beat_valid_o, done_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/rv64g_l1_vlsu_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : rv64g_l1_vlsu_bank_sched
// Brief    : Resolves lane/bank conflicts of one vector request, issuing
//            per-bank tag reads and a beat aligned with the returned data.
// Revision : 1.0 - initial release
// ============================================================================
module rv64g_l1_vlsu_bank_sched #(
  parameter int NUM_LANES = 8,
  parameter int NUM_BANKS = 8,
  parameter int INDEX_W   = 5,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  rv64g_l1_vlsu_bank_sched_if.slave  bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                        r_state;
  logic [NUM_LANES-1:0]          r_pending;
  logic [NUM_LANES*64-1:0]       r_lane_addr;
  logic [NUM_BANKS-1:0]          r_bank_active;
  logic [NUM_BANKS*LANE_W-1:0]   r_bank_src_lane;
  logic [NUM_LANES-1:0]          r_beat_lane_mask;
  logic                          r_beat_valid;
  logic                          r_done;

  logic [60:0]                   w_word [NUM_LANES];
  logic [NUM_BANKS-1:0]          w_grant;
  logic [LANE_W-1:0]             w_src [NUM_BANKS];
  logic [NUM_LANES-1:0]          w_cover;
  logic [NUM_LANES-1:0]          w_pending_nxt;
  logic [NUM_BANKS*LANE_W-1:0]   w_src_flat;
  logic [NUM_BANKS*INDEX_W-1:0]  w_index_flat;
  logic                          w_issue;

  // Word address (addr[63:3]); bank sits in its low bits, set index above.
  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_word
      assign w_word[l] = r_lane_addr[l*64+3 +: 61];
    end
  endgenerate

  // Scanning lanes high to low leaves the lowest pending lane as owner.
  always_comb begin
    w_grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_src[b] = '0;
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
        if (r_pending[l] && (w_word[l][BANK_W-1:0] == BANK_W'(b))) begin
          w_grant[b] = 1'b1;
          w_src[b]   = LANE_W'(l);
        end
      end
    end
  end

  always_comb begin
    w_cover = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_grant[b] && r_pending[l] && (w_word[l] == w_word[w_src[b]])) begin
          w_cover[l] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_src_flat   = '0;
    w_index_flat = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_src_flat[b*LANE_W +: LANE_W] = w_src[b];
      if (w_grant[b]) begin
        w_index_flat[b*INDEX_W +: INDEX_W] = w_word[w_src[b]][3 +: INDEX_W];
      end
    end
  end

  assign w_issue        = (r_state == ST_ISSUE);
  assign w_pending_nxt  = r_pending & ~w_cover;

  assign bus.req_ready_o      = (r_state == ST_IDLE);
  assign bus.busy_o           = w_issue;
  assign bus.lane_addr_o      = r_lane_addr;
  assign bus.tag_rd_en_o      = w_issue ? w_grant : '0;
  assign bus.tag_rd_index_o   = w_issue ? w_index_flat : '0;
  assign bus.bank_active_o    = r_bank_active;
  assign bus.bank_src_lane_o  = r_bank_src_lane;
  assign bus.beat_lane_mask_o = r_beat_lane_mask;
  assign bus.beat_valid_o     = r_beat_valid;
  assign bus.done_o           = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_pending        <= '0;
      r_lane_addr      <= '0;
      r_bank_active    <= '0;
      r_bank_src_lane  <= '0;
      r_beat_lane_mask <= '0;
      r_beat_valid     <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_bank_active    <= '0;
      r_bank_src_lane  <= '0;
      r_beat_lane_mask <= '0;
      r_beat_valid     <= 1'b0;
      r_done           <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            r_lane_addr <= bus.req_lane_addr_i;
            r_pending   <= bus.req_lane_valid_i;
            if (bus.req_lane_valid_i != '0) begin
              r_state <= ST_ISSUE;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // A killed cycle still drove its reads; only the beat is dropped.
          if (bus.kill_i) begin
            r_pending <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_pending        <= w_pending_nxt;
            r_bank_active    <= w_grant;
            r_bank_src_lane  <= w_src_flat;
            r_beat_lane_mask <= w_cover;
            r_beat_valid     <= 1'b1;
            if (w_pending_nxt == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
